// File: rtl/wishbone_master_if.sv
// Wishbone classic bus bundle between one initiator and the SoC responders.
// The master drives cycle/strobe/address/data; the slave returns read data and terminations.
interface wishbone_master_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface

// File: rtl/wishbone_master.sv
// Wishbone classic single-transfer initiator (err > ack > rty, bounded retries); WISHBONE_MASTER_TIMEOUT_EN adds a BUS timeout.
// Latency: request accepted at edge N, cyc/stb after N, response valid after the edge that samples the termination.
// Backpressure: req_ready_o only in IDLE; the response is held until resp_ready_i, so one transfer is outstanding.
module wishbone_master #(
    parameter int MAX_RETRIES    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_addr_i,
    input  logic              req_we_i,
    input  logic [3:0]        req_sel_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    wishbone_master_if.master wb
);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES);

    generate
        if (MAX_RETRIES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("wishbone_master: MAX_RETRIES must be >= 0 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

    state_t        state;
    logic [RW-1:0] retry_cnt;
    logic          tmo_hit;
    logic          bus_fail;

`ifdef WISHBONE_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // Held at zero outside BUS, so every entry (including from BACKOFF) restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state != BUS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // Error outcomes: explicit err, rty with retries spent, or timeout when nothing terminated.
    assign bus_fail = wb.err_i
                    | (~wb.ack_i &  wb.rty_i & (retry_cnt == RETRY_LAST))
                    | (~wb.ack_i & ~wb.rty_i & tmo_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            retry_cnt    <= '0;
            wb.cyc_o     <= 1'b0;
            wb.stb_o     <= 1'b0;
            wb.we_o      <= 1'b0;
            wb.adr_o     <= '0;
            wb.sel_o     <= '0;
            wb.dat_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        wb.adr_o    <= req_addr_i;
                        wb.we_o     <= req_we_i;
                        wb.sel_o    <= req_sel_i;
                        wb.dat_o    <= req_wdata_i;
                        wb.cyc_o    <= 1'b1;
                        wb.stb_o    <= 1'b1;
                        retry_cnt   <= '0;
                        req_ready_o <= 1'b0;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    if (bus_fail) begin
                        wb.cyc_o     <= 1'b0;
                        wb.stb_o     <= 1'b0;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= '0;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end else if (wb.ack_i) begin
                        wb.cyc_o     <= 1'b0;
                        wb.stb_o     <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= wb.we_o ? 32'h0 : wb.dat_i;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end else if (wb.rty_i) begin
                        wb.cyc_o  <= 1'b0;
                        wb.stb_o  <= 1'b0;
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= BACKOFF;
                    end
                end
                BACKOFF: begin
                    wb.cyc_o <= 1'b1;
                    wb.stb_o <= 1'b1;
                    state    <= BUS;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
